// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg
// Shared definitions for the memory BIST controller.
//   state_t      : controller state encoding (IDLE, W0, R0, W1, R1, DONE)
//   is_active    : true in the four march phases that drive the memory
//   is_write     : true in the phases that write (W0, W1)
//   is_invert    : true in the phases that use the inverted checkerboard (W1, R1)
//   next_phase   : march phase that follows a completed address sweep
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      R0   = 3'd2,
      W1   = 3'd3,
      R1   = 3'd4,
      DONE = 3'd5
   } state_t;

   function automatic logic is_active(input state_t s);
      return (s == W0) || (s == R0) || (s == W1) || (s == R1);
   endfunction

   function automatic logic is_write(input state_t s);
      return (s == W0) || (s == W1);
   endfunction

   function automatic logic is_invert(input state_t s);
      return (s == W1) || (s == R1);
   endfunction

   // R1 has no successor phase here; the controller handles its exit itself.
   function automatic state_t next_phase(input state_t s);
      case (s)
         W0:      return R0;
         R0:      return W1;
         W1:      return R1;
         default: return DONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// mem_bist_addr_gen
// Address sweep counter for the BIST march.
// Ports:
//   clk_i   : clock, all logic on posedge
//   rst_i   : synchronous active-high reset, counter returns to 0
//   clear_i : synchronous clear to 0 (new test or aborted test)
//   inc_i   : advance one address (one completed memory handshake)
//   addr_o  : current address
//   last_o  : high while addr_o is the final tested address DEPTH-1
module mem_bist_addr_gen #(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   assign last_o = (addr_o == LAST_ADDR);

   // The sweep ends at DEPTH-1 rather than the natural counter roll-over, so
   // the wrap back to 0 is explicit. Clear wins over increment so an aborted
   // test leaves the counter parked at 0.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         addr_o <= '0;
      end else if (inc_i) begin
         addr_o <= last_o ? '0 : addr_o + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl
// Checkerboard march BIST controller (W0, R0, W1, R1 over addresses
// 0..DEPTH-1) acting as the sole master of a valid/ready single-port memory.
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   start_i               : start pulse, honoured only in IDLE or DONE
//   busy_o, done_o        : test running / test finished
//   pass_o, fail_addr_o   : result and first failing address (valid with done_o)
//   mem_addr_o, mem_wr_rd_o, mem_wr_data_o, mem_valid_o : memory request
//   mem_rd_data_i, mem_ready_i                          : memory response
//   err_cnt_o             : saturating mismatch count (MEM_BIST_ERR_COUNT_EN only)
// Build option:
//   MEM_BIST_ERR_COUNT_EN : count mismatches and run every phase to the end
//                           instead of stopping on the first mismatch.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int                WIDTH      = 2,
   parameter int                DEPTH      = 8,
   parameter int                ADDR_WIDTH = 3,
   parameter logic [WIDTH-1:0]  PATTERN    = WIDTH'(2'b01)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_wr_rd_o,
   output logic [WIDTH-1:0]      mem_wr_data_o,
   output logic                  mem_valid_o,
   input  logic [WIDTH-1:0]      mem_rd_data_i,
   input  logic                  mem_ready_i
`ifdef MEM_BIST_ERR_COUNT_EN
   ,
   output logic [ADDR_WIDTH+1:0] err_cnt_o
`endif
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    last;
   logic                    hs;
   logic                    start_ok;
   logic                    mismatch;
   logic                    abort;
   logic                    clean_run;
   logic [WIDTH-1:0]        expected;

   // A transfer completes whenever our request meets ready; start is only
   // honoured between tests.
   assign hs       = mem_valid_o & mem_ready_i;
   assign start_ok = start_i && ((state == IDLE) || (state == DONE));

   // Checkerboard: odd addresses flip the base pattern, the second half of
   // the march flips everything again. The same word is the write data and
   // the read reference.
   assign expected = PATTERN ^ {WIDTH{addr[0]}} ^ {WIDTH{is_invert(state)}};
   assign mismatch = hs && is_active(state) && !is_write(state)
                     && (mem_rd_data_i != expected);

`ifdef MEM_BIST_ERR_COUNT_EN
   assign abort     = 1'b0;
   assign clean_run = (err_cnt_o == '0) && !mismatch;
`else
   assign abort     = mismatch;
   assign clean_run = 1'b1;
`endif

   // Request fields are pure decodes of registered state and address, so
   // they hold still for as long as the memory keeps ready low. Outside the
   // march phases they read as zero.
   assign mem_addr_o    = addr;
   assign mem_wr_rd_o   = is_write(state);
   assign mem_wr_data_o = is_active(state) ? expected : '0;

   mem_bist_addr_gen #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (start_ok | abort),
      .inc_i   (hs),
      .addr_o  (addr),
      .last_o  (last)
   );

   // Main sequencer. Valid stays high across a whole march so back-to-back
   // handshakes run one per cycle; each phase ends on the handshake at the
   // last address, and the test ends after R1 or, in the aborting build, on
   // the first read mismatch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         mem_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_addr_o <= '0;
`ifdef MEM_BIST_ERR_COUNT_EN
         err_cnt_o   <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state       <= W0;
                  mem_valid_o <= 1'b1;
                  busy_o      <= 1'b1;
                  done_o      <= 1'b0;
                  pass_o      <= 1'b0;
                  fail_addr_o <= '0;
`ifdef MEM_BIST_ERR_COUNT_EN
                  err_cnt_o   <= '0;
`endif
               end
            end
            W0, R0, W1, R1: begin
               if (hs) begin
                  if (mismatch) begin
`ifdef MEM_BIST_ERR_COUNT_EN
                     if (err_cnt_o == '0) begin
                        fail_addr_o <= addr;
                     end
                     if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + 1'b1;
                     end
`else
                     fail_addr_o <= addr;
                     state       <= DONE;
                     mem_valid_o <= 1'b0;
                     busy_o      <= 1'b0;
                     done_o      <= 1'b1;
                     pass_o      <= 1'b0;
`endif
                  end
                  if (!abort && last) begin
                     if (state == R1) begin
                        state       <= DONE;
                        mem_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        pass_o      <= clean_run;
                     end else begin
                        state <= next_phase(state);
                     end
                  end
               end
            end
            default: begin
               state       <= IDLE;
               mem_valid_o <= 1'b0;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule
